// File: rtl/button_event_decoder.sv
// button_event_decoder: turns a debounced button level into press/release/click/double/long event pulses.
// Optional macro AUTO_REPEAT_EN adds a periodic o_repeat pulse train while the button is held past long.
`default_nettype none

module button_event_decoder #(
    parameter int LONG_TICKS   = 100,
    parameter int GAP_TICKS    = 25,
    parameter int REPEAT_TICKS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    input  logic i_tick10ms,
    output logic o_press,
    output logic o_release,
    output logic o_click,
    output logic o_double,
    output logic o_long,
    output logic o_repeat
);

    localparam int MAX_LG  = (LONG_TICKS > GAP_TICKS) ? LONG_TICKS : GAP_TICKS;
    localparam int MAX_T   = (MAX_LG > REPEAT_TICKS) ? MAX_LG : REPEAT_TICKS;
    localparam int CNT_W   = $clog2(MAX_T + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        GAP    = 3'd2,
        PRESS2 = 3'd3,
        LONG   = 3'd4
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d, cnt_inc;
    logic               level_q;
    logic               rise, fall, tick_ok;
    logic               click_d, double_d, long_d;

    assign rise    = i_level & ~level_q;
    assign fall    = ~i_level & level_q;
    // An edge in the same cycle as a tick takes priority; the tick is dropped.
    assign tick_ok = i_tick10ms & ~rise & ~fall;
    assign cnt_inc = cnt + CNT_W'(1);

`ifdef AUTO_REPEAT_EN
    logic repeat_d;
    logic repeat_q;
    assign o_repeat = repeat_q;
`else
    assign o_repeat = 1'b0;
`endif

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        click_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
`ifdef AUTO_REPEAT_EN
        repeat_d = 1'b0;
`endif
        if (tick_ok && state != IDLE) begin
            cnt_d = cnt_inc;
        end
        case (state)
            IDLE: begin
                if (rise) state_d = PRESS1;
            end
            PRESS1: begin
                if (fall) begin
                    state_d = GAP;
                end else if (tick_ok && cnt_inc == CNT_W'(LONG_TICKS)) begin
                    long_d  = 1'b1;
                    state_d = LONG;
                end
            end
            GAP: begin
                if (rise) begin
                    state_d = PRESS2;
                end else if (tick_ok && cnt_inc == CNT_W'(GAP_TICKS)) begin
                    click_d = 1'b1;
                    state_d = IDLE;
                end
            end
            PRESS2: begin
                if (fall) begin
                    double_d = 1'b1;
                    state_d  = IDLE;
                end else if (tick_ok && cnt_inc == CNT_W'(LONG_TICKS)) begin
                    long_d  = 1'b1;
                    state_d = LONG;
                end
            end
            LONG: begin
                if (fall) begin
                    state_d = IDLE;
`ifdef AUTO_REPEAT_EN
                end else if (tick_ok && cnt_inc == CNT_W'(REPEAT_TICKS)) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end
`else
                end else begin
                    cnt_d = cnt;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            level_q   <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_click   <= 1'b0;
            o_double  <= 1'b0;
            o_long    <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            level_q   <= i_level;
            o_press   <= rise;
            o_release <= fall;
            o_click   <= click_d;
            o_double  <= double_d;
            o_long    <= long_d;
        end
    end

`ifdef AUTO_REPEAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= repeat_d;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: event-history model plus directed scenarios with literal pulse counts.
`default_nettype none

module tb_button_event_decoder;

    localparam int LONG_T = 4;
    localparam int GAP_T  = 3;
    localparam int REP_T  = 2;
`ifdef AUTO_REPEAT_EN
    localparam int REP_ON = 1;
`else
    localparam int REP_ON = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic i_level = 1'b0;
    logic i_tick10ms = 1'b0;
    logic o_press, o_release, o_click, o_double, o_long, o_repeat;

    int errors = 0;
    int checks = 0;
    int phase  = 0;

    always #5 clk = ~clk;

    button_event_decoder #(
        .LONG_TICKS  (LONG_T),
        .GAP_TICKS   (GAP_T),
        .REPEAT_TICKS(REP_T)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_level   (i_level),
        .i_tick10ms(i_tick10ms),
        .o_press   (o_press),
        .o_release (o_release),
        .o_click   (o_click),
        .o_double  (o_double),
        .o_long    (o_long),
        .o_repeat  (o_repeat)
    );

    // Model: remembers how many presses are in the current gesture, whether it went long,
    // and how many ticks have elapsed in the current hold / gap / repeat interval.
    int m_lvl = 0, m_npress = 0, m_longed = 0, m_ticks = 0;
    int e_press = 0, e_release = 0, e_click = 0, e_double = 0, e_long = 0, e_repeat = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_lvl = 0; m_npress = 0; m_longed = 0; m_ticks = 0;
            e_press = 0; e_release = 0; e_click = 0; e_double = 0; e_long = 0; e_repeat = 0;
        end else begin
            e_press   = (i_level && m_lvl == 0) ? 1 : 0;
            e_release = (!i_level && m_lvl == 1) ? 1 : 0;
            e_click = 0; e_double = 0; e_long = 0; e_repeat = 0;
            if (e_press == 1) begin
                if (m_npress < 2) begin
                    m_npress = m_npress + 1;
                    m_ticks  = 0;
                end
            end else if (e_release == 1) begin
                if (m_longed == 1 || m_npress == 2) begin
                    e_double = (m_longed == 0) ? 1 : 0;
                    m_npress = 0; m_longed = 0; m_ticks = 0;
                end else begin
                    m_ticks = 0;
                end
            end else if (i_tick10ms && m_npress > 0) begin
                m_ticks = m_ticks + 1;
                if (m_longed == 1) begin
                    if (REP_ON == 1 && m_ticks == REP_T) begin
                        e_repeat = 1;
                        m_ticks  = 0;
                    end
                end else if (m_lvl == 1 && m_ticks == LONG_T) begin
                    e_long = 1; m_longed = 1; m_ticks = 0;
                end else if (m_lvl == 0 && m_ticks == GAP_T) begin
                    e_click = 1; m_npress = 0; m_ticks = 0;
                end
            end
            m_lvl = i_level ? 1 : 0;
        end
    end

    int n_press, n_release, n_click, n_double, n_long, n_repeat;
    int x_click, x_double, x_long, x_repeat;

    task automatic chk(input string name, input int act, input int req);
        checks = checks + 1;
        if (act != req) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic clear_counts();
        n_press = 0; n_release = 0; n_click = 0; n_double = 0; n_long = 0; n_repeat = 0;
        x_click = 0; x_double = 0; x_long = 0; x_repeat = 0;
    endtask

    // One clock: compare all outputs against the model mid-cycle, then advance inputs after the edge.
    task automatic step();
        @(negedge clk);
        chk("o_press",   int'(o_press),   e_press);
        chk("o_release", int'(o_release), e_release);
        chk("o_click",   int'(o_click),   e_click);
        chk("o_double",  int'(o_double),  e_double);
        chk("o_long",    int'(o_long),    e_long);
        chk("o_repeat",  int'(o_repeat),  e_repeat);
        n_press   += int'(o_press);
        n_release += int'(o_release);
        n_click   += int'(o_click);
        n_double  += int'(o_double);
        n_long    += int'(o_long);
        n_repeat  += int'(o_repeat);
        x_click   += e_click;
        x_double  += e_double;
        x_long    += e_long;
        x_repeat  += e_repeat;
        @(posedge clk);
        #1;
        phase = phase + 1;
        i_tick10ms = (phase % 4 == 0);
    endtask

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            while (!i_tick10ms) step();
        end
    endtask

    task automatic set_level(input logic v);
        step();
        while (i_tick10ms) step();
        i_level = v;
    endtask

    task automatic chk_counts(input string tag, input int p, input int r, input int c,
                              input int d, input int l, input int rp);
        chk({tag, ".press"},   n_press,   p);
        chk({tag, ".release"}, n_release, r);
        chk({tag, ".click"},   n_click,   c);
        chk({tag, ".double"},  n_double,  d);
        chk({tag, ".long"},    n_long,    l);
        chk({tag, ".repeat"},  n_repeat,  rp);
        chk({tag, ".m_click"},  x_click,  c);
        chk({tag, ".m_double"}, x_double, d);
        chk({tag, ".m_long"},   x_long,   l);
        chk({tag, ".m_repeat"}, x_repeat, rp);
    endtask

    initial begin
        clear_counts();
        // Reset held with the button already down, then released.
        i_level = 1'b1;
        repeat (3) step();
        chk("rst_outputs_zero", int'({o_press, o_release, o_click, o_double, o_long, o_repeat}), 0);
        rst = 1'b1;
        step();
        chk("press_after_rst", int'(o_press), 1);
        set_level(1'b0);
        wait_ticks(4);
        step();
        chk_counts("s1", 1, 1, 1, 0, 0, 0);

        // Short press then gap timeout: single click.
        clear_counts();
        set_level(1'b1);
        wait_ticks(2);
        set_level(1'b0);
        wait_ticks(4);
        step();
        chk_counts("click", 1, 1, 1, 0, 0, 0);

        // Two short presses inside the gap window: double-click.
        clear_counts();
        set_level(1'b1);
        wait_ticks(1);
        set_level(1'b0);
        wait_ticks(1);
        set_level(1'b1);
        wait_ticks(1);
        set_level(1'b0);
        wait_ticks(4);
        step();
        chk_counts("double", 2, 2, 0, 1, 0, 0);

        // Long hold: long at tick 4, repeats at ticks 6 and 8 when enabled.
        clear_counts();
        set_level(1'b1);
        wait_ticks(8);
        step();
        set_level(1'b0);
        wait_ticks(4);
        step();
        chk_counts("long", 1, 1, 0, 0, 1, 2 * REP_ON);

        // Second press lands exactly on the gap-terminal tick: edge wins, no click.
        clear_counts();
        set_level(1'b1);
        wait_ticks(1);
        set_level(1'b0);
        wait_ticks(2);
        step();
        while (!i_tick10ms) step();
        i_level = 1'b1;
        wait_ticks(3);
        set_level(1'b0);
        wait_ticks(4);
        step();
        chk_counts("coincide", 2, 2, 0, 1, 0, 0);

        // Reset pulsed during the second press: gesture aborted silently.
        set_level(1'b1);
        wait_ticks(1);
        set_level(1'b0);
        set_level(1'b1);
        step();
        step();
        rst = 1'b0;
        i_level = 1'b0;
        clear_counts();
        step();
        chk("rst_mid_outputs_zero", int'({o_press, o_release, o_click, o_double, o_long, o_repeat}), 0);
        step();
        step();
        rst = 1'b1;
        wait_ticks(5);
        step();
        chk_counts("abort", 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
